// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised XNOR-feedback LFSR with a seed-load handshake,
// lock-up seed substitution, a valid/ready output stream and a beat counter.
module lfsr_gen #(
    parameter int                WIDTH        = 64,
    parameter logic [63:0]       TAPS         = 64'hD800_0000_0000_0000,
    parameter int                STEPS        = 1,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 1,
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             seed_fixed,
    output logic [CNT_W-1:0] beat_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LOCKUP   = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           fsm_q;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fixed_q, fixed_d;
    logic             load, adv, lockup;

    // STEPS single shifts unrolled into one combinational advance.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        logic             fb;
        v = s;
        for (int k = 0; k < STEPS; k++) begin
            fb = ~(^(v & TAP_MASK));
            v  = {v[WIDTH-2:0], fb};
        end
        return v;
    endfunction

    // A seed is always acceptable outside reset; the reset cycle is ignored
    // by the reset priority in the register block.
    assign seed_ready = 1'b1;
    assign load       = seed_valid & seed_ready;
    assign adv        = (fsm_q == RUN) & out_ready;
    assign lockup     = (seed == LOCKUP);

    // Next-state data: a load beats a simultaneous advance.
    always_comb begin
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        fixed_d = fixed_q;
        if (load) begin
            lfsr_d  = lockup ? DEFAULT_SEED : seed;
            fixed_d = lockup;
            cnt_d   = '0;
        end else if (adv) begin
            lfsr_d = advance(lfsr_q);
            cnt_d  = cnt_q + CNT_ONE;
        end
    end

    // FSM and state registers; reset returns everything to a deterministic IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            fixed_q <= fixed_d;
            if (load) begin
                fsm_q <= RUN;
            end
        end
    end

    assign out_valid  = (fsm_q == RUN);
    assign out_data   = lfsr_q;
    assign seed_fixed = fixed_q;
    assign beat_count = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: three lfsr_gen configurations (16-bit step 1, 16-bit step 4,
// 64-bit defaults) checked every cycle against a behavioural model, plus
// literal expectations taken from hand-worked sequences.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [63:0] seed_a [3];
    logic        sv     [3];
    logic        ordy   [3];
    logic        rst    [3];

    logic [15:0] od0, od1;
    logic [63:0] od2;
    logic        ov0, ov1, ov2, sr0, sr1, sr2, sf0, sf1, sf2;
    logic [31:0] bc0, bc1, bc2;

    lfsr_gen #(.WIDTH(16), .TAPS(64'h0000_0000_0000_D008), .STEPS(1),
               .DEFAULT_SEED(16'h0001), .CNT_W(32)) u0 (
        .clk(clk), .reset(rst[0]), .seed(seed_a[0][15:0]), .seed_valid(sv[0]),
        .seed_ready(sr0), .out_ready(ordy[0]), .out_valid(ov0), .out_data(od0),
        .seed_fixed(sf0), .beat_count(bc0));

    lfsr_gen #(.WIDTH(16), .TAPS(64'h0000_0000_0000_D008), .STEPS(4),
               .DEFAULT_SEED(16'h0001), .CNT_W(32)) u1 (
        .clk(clk), .reset(rst[1]), .seed(seed_a[1][15:0]), .seed_valid(sv[1]),
        .seed_ready(sr1), .out_ready(ordy[1]), .out_valid(ov1), .out_data(od1),
        .seed_fixed(sf1), .beat_count(bc1));

    lfsr_gen u2 (
        .clk(clk), .reset(rst[2]), .seed(seed_a[2]), .seed_valid(sv[2]),
        .seed_ready(sr2), .out_ready(ordy[2]), .out_valid(ov2), .out_data(od2),
        .seed_fixed(sf2), .beat_count(bc2));

    logic [63:0] od [3];
    logic        ov [3];
    logic        sr [3];
    logic        sf [3];
    logic [31:0] bc [3];
    assign od[0] = {48'd0, od0};
    assign od[1] = {48'd0, od1};
    assign od[2] = od2;
    assign ov[0] = ov0; assign ov[1] = ov1; assign ov[2] = ov2;
    assign sr[0] = sr0; assign sr[1] = sr1; assign sr[2] = sr2;
    assign sf[0] = sf0; assign sf[1] = sf1; assign sf[2] = sf2;
    assign bc[0] = bc0; assign bc[1] = bc1; assign bc[2] = bc2;

    // Behavioural model configuration and state
    int          m_w    [3] = '{16, 16, 64};
    int          m_st   [3] = '{1, 4, 1};
    logic [63:0] m_tap  [3] = '{64'hD008, 64'hD008, 64'hD800_0000_0000_0000};
    logic [63:0] m_state[3];
    logic        m_valid[3];
    logic        m_fixed[3];
    logic [31:0] m_cnt  [3];

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Count tapped ones; an even count feeds back a 1.
    function automatic logic [63:0] model_step(input logic [63:0] s, input int w,
                                               input logic [63:0] taps, input int steps);
        logic [63:0] v;
        int          ones;
        v = s;
        for (int k = 0; k < steps; k++) begin
            ones = 0;
            for (int j = 0; j < w; j++)
                if (v[j] && taps[j]) ones++;
            v = ((v << 1) | {63'd0, (ones % 2) == 0}) & wmask(w);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs present at each rising edge
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [63:0] s;
            s = seed_a[i] & wmask(m_w[i]);
            if (rst[i]) begin
                m_state[i] <= '0; m_valid[i] <= 1'b0; m_fixed[i] <= 1'b0; m_cnt[i] <= '0;
            end else if (sv[i]) begin
                m_state[i] <= (s == wmask(m_w[i])) ? 64'd1 : s;
                m_fixed[i] <= (s == wmask(m_w[i]));
                m_cnt[i]   <= '0;
                m_valid[i] <= 1'b1;
            end else if (m_valid[i] && ordy[i]) begin
                m_state[i] <= model_step(m_state[i], m_w[i], m_tap[i], m_st[i]);
                m_cnt[i]   <= m_cnt[i] + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.out_valid", i),  {63'd0, ov[i]}, {63'd0, m_valid[i]});
                chk($sformatf("u%0d.out_data", i),   od[i], m_state[i]);
                chk($sformatf("u%0d.beat_count", i), {32'd0, bc[i]}, {32'd0, m_cnt[i]});
                chk($sformatf("u%0d.seed_fixed", i), {63'd0, sf[i]}, {63'd0, m_fixed[i]});
                if (!rst[i]) chk($sformatf("u%0d.seed_ready", i), {63'd0, sr[i]}, 64'd1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            seed_a[i] = '0; sv[i] = 1'b0; ordy[i] = 1'b0; rst[i] = 1'b1;
        end
        @(negedge clk); @(negedge clk);
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle.valid", {63'd0, ov0}, 64'd0);
            chk("idle.data",  {48'd0, od0}, 64'd0);
            chk("idle.beat",  {32'd0, bc0}, 64'd0);
        end

        // Basic sequence from seed 0001
        begin
            logic [15:0] exp_seq [5];
            exp_seq = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001E};
            seed_a[0] = 64'h1; sv[0] = 1'b1; ordy[0] = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                sv[0] = 1'b0;
                chk($sformatf("basic.data[%0d]", k), {48'd0, od0}, {48'd0, exp_seq[k]});
                chk($sformatf("basic.beat[%0d]", k), {32'd0, bc0}, k);
            end
        end

        // Backpressure holds 0003
        seed_a[0] = 64'h1; sv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk); sv[0] = 1'b0;
        @(negedge clk); ordy[0] = 1'b0;
        chk("bp.start", {48'd0, od0}, 64'h3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp.hold", {48'd0, od0}, 64'h3);
        end

        // Load colliding with an accepted beat
        ordy[0] = 1'b1; seed_a[0] = 64'h00F0; sv[0] = 1'b1;
        @(negedge clk); sv[0] = 1'b0; ordy[0] = 1'b0;
        chk("collide.data", {48'd0, od0}, 64'h00F0);
        chk("collide.beat", {32'd0, bc0}, 64'd0);

        // Lock-up guard
        seed_a[0] = 64'hFFFF; sv[0] = 1'b1;
        @(negedge clk);
        chk("lockup.data",  {48'd0, od0}, 64'h1);
        chk("lockup.fixed", {63'd0, sf0}, 64'd1);
        seed_a[0] = 64'h2;
        @(negedge clk); sv[0] = 1'b0;
        chk("reload.data",  {48'd0, od0}, 64'h2);
        chk("reload.fixed", {63'd0, sf0}, 64'd0);

        // Multi-step
        seed_a[1] = 64'h1; sv[1] = 1'b1; ordy[1] = 1'b1;
        @(negedge clk); sv[1] = 1'b0;
        chk("multi.first", {48'd0, od1}, 64'h0001);
        @(negedge clk); ordy[1] = 1'b0;
        chk("multi.second", {48'd0, od1}, 64'h001E);

        // 64-bit defaults with reset mid-run
        seed_a[2] = 64'h1; sv[2] = 1'b1; ordy[2] = 1'b1;
        @(negedge clk); sv[2] = 1'b0;
        chk("w64.first", od2, 64'h1);
        @(negedge clk);
        chk("w64.beat1", od2, 64'h3);
        @(negedge clk); @(negedge clk);
        chk("w64.count3", {32'd0, bc2}, 64'd3);
        rst[2] = 1'b1; sv[2] = 1'b1; seed_a[2] = 64'h5;
        @(negedge clk); rst[2] = 1'b0; sv[2] = 1'b0;
        chk("w64.rst.valid", {63'd0, ov2}, 64'd0);
        chk("w64.rst.data",  od2, 64'd0);
        chk("w64.rst.beat",  {32'd0, bc2}, 64'd0);
        @(negedge clk);
        chk("w64.idle.valid", {63'd0, ov2}, 64'd0);
        seed_a[2] = 64'h1; sv[2] = 1'b1;
        @(negedge clk); sv[2] = 1'b0;
        chk("w64.reload", od2, 64'h1);
        @(negedge clk);
        chk("w64.reload.beat1", od2, 64'h3);

        // Randomised traffic on all three instances
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                rst[i]    = ($urandom_range(0, 59) == 0);
                sv[i]     = ($urandom_range(0, 7) == 0);
                seed_a[i] = ($urandom_range(0, 5) == 0) ? {64{1'b1}} : {$urandom, $urandom};
                ordy[i]   = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
        end

        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; rst[i] = 1'b0;
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised XNOR-feedback linear-feedback shift register with a seed-load handshake and a valid/ready output stream. It generalises the team's fixed 16-bit and 64-bit LFSRs to any width from 4 to 64 bits, any tap mask, and several bit-advances per output beat. It also protects against the XNOR lock-up seed and keeps a beat counter. It sits between the seed/config source and the consumers of pseudo-random words (scramblers, test-pattern generators), and replaces ad-hoc per-width LFSR copies.

## Interface
- WIDTH, 64: register width; legal range 4..64.
- TAPS, 64'hD800_0000_0000_0000: feedback mask, bit i set means state[i] is a tap. Only bits [WIDTH-1:0] are used. The number of set bits must be even and non-zero.
- STEPS, 1: shifts applied per accepted output beat; legal range 1..WIDTH.
- DEFAULT_SEED, 1: substitute seed used when a lock-up seed is loaded. Must not be all-ones in [WIDTH-1:0].
- CNT_W, 32: beat counter width.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seed  in  WIDTH  seed value.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  seed can be accepted.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  WIDTH  current LFSR state.
- seed_fixed  out  1  sticky flag: the last loaded seed was lock-up and was substituted.
- beat_count  out  CNT_W  output beats accepted since the last load.

## Operation
- Feedback for one shift: fb = ~(^(state & TAPS[WIDTH-1:0])). The next state is {state[WIDTH-2:0], fb}.
- One advance applies the single shift STEPS times in one cycle, as unrolled combinational logic. There is no multi-cycle stepping.
- Lock-up state is all-ones: with an even tap count, fb = 1 keeps the state all-ones.
- States:
  - IDLE (after reset): out_valid = 0, seed_ready = 1. The state register holds 0; it is don't-care but must be deterministic.
  - RUN: out_valid = 1, seed_ready = 1.
- Seed load: happens when seed_valid && seed_ready.
  - state <= (seed == all-ones) ? DEFAULT_SEED : seed.
  - seed_fixed <= (seed == all-ones).
  - beat_count <= 0.
  - FSM goes to RUN.
- Load is accepted in both IDLE and RUN. A reload in RUN restarts the sequence.
- Advance: happens when out_valid && out_ready.
  - state <= STEPS-fold next state.
  - beat_count <= beat_count + 1, wrapping modulo 2^CNT_W with no saturation.
- If a load and an advance occur in the same cycle, the load wins. The current beat still counts as consumed by the downstream side, but state and beat_count take the load values.
- With out_ready held high, the block produces one word per cycle indefinitely. There is no terminal state.
- Reset while in RUN: next cycle is IDLE with all outputs at reset values. Any seed offered in the reset cycle is ignored.

## Timing
- Reset values: out_valid = 0, seed_ready = 1, out_data = 0, seed_fixed = 0, beat_count = 0. FSM = IDLE.
- Seed accepted at edge N: out_valid = 1 and out_data = loaded (possibly substituted) seed, visible after edge N. Latency is 1 cycle.
- Beat accepted at edge N: out_data shows the advanced state after edge N. There is zero bubble, for a throughput of 1 word per cycle.
- out_data and out_valid are registered with no combinational path from inputs. seed_ready is constant 1 outside reset.
- out_data is held stable while out_valid && !out_ready.

## Test plan
- Reset then idle: with WIDTH=16, TAPS=16'hD008, STEPS=1, apply reset and no seed. Expect out_valid = 0, out_data = 0, beat_count = 0 for 10 cycles.
- Basic sequence: same config, load seed 16'h0001 with out_ready = 1. Expect out_data 0001, 0003, 0007, 000F, 001E on consecutive cycles, and beat_count 0, 1, 2, 3, 4.
- Multi-step: STEPS=4, seed 16'h0001, one accepted beat. Expect out_data 0001 then 001E.
- Lock-up guard: load 16'hFFFF. Expect out_data = DEFAULT_SEED = 0001 and seed_fixed = 1. A later load of 0002 clears seed_fixed.
- Backpressure and collision:
  - Hold out_ready = 0 for 5 cycles: out_data stays 0003.
  - Load seed 0x00F0 in the same cycle as an accepted beat: next out_data = 00F0 and beat_count = 0.
- Reset mid-run and 64-bit default: with default parameters and seed 64'h1, apply reset after 3 beats. Expect IDLE the next cycle. Reload 64'h1 and check beat 1 = 64'h3.
